// File: rtl/arb_pkg.sv
// Shared types, default sizing and helpers for the round-robin ring arbiter.
package arb_pkg;

  // Arbiter FSM: waiting for a request, or a grant is held by one owner.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Default sizing and the widths derived from it.
  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 8;
  localparam int N_MAX        = 16;
  localparam int ID_W         = $clog2(N_DEF);
  localparam int CNT_W        = $clog2(MAX_HOLD_DEF + 1);

  // Width of a requester index for n requesters (n >= 2).
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a hold counter that reaches m without wrapping.
  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

  // Rotate the low n bits of a one-hot vector left by one, wrapping bit n-1 to 0.
  function automatic logic [N_MAX-1:0] rotl1(input logic [N_MAX-1:0] v, input int n);
    logic [N_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (i < n) begin
        r[(i + 1 == n) ? 0 : i + 1] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_ring_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after the one-hot
// pointer, searching circularly. Uses the doubled-vector subtract trick so the
// search wraps without a per-N priority chain.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick,
  output logic         valid
);

  logic [2*N-1:0] w_dbl_req;
  logic [2*N-1:0] w_dbl_ptr;
  logic [2*N-1:0] w_dbl_gnt;

  // Subtracting the pointer from the doubled request vector borrows through the
  // clear bits below the first eligible request; masking isolates that bit.
  always_comb begin
    w_dbl_req = {req, req};
    w_dbl_ptr = {{N{1'b0}}, ptr};
    w_dbl_gnt = w_dbl_req & ~(w_dbl_req - w_dbl_ptr);
    pick      = w_dbl_gnt[N-1:0] | w_dbl_gnt[2*N-1:N];
    valid     = |req;
  end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority pointer and a hold-time
// limit. Protocol: a requester raises req[i] and keeps it high for as long as it
// wants the resource; gnt[i] marks ownership and is held until req[i] drops or
// MAX_HOLD cycles elapse, after which one IDLE cycle always precedes the next
// grant. Non-owner requests never preempt the current owner.
module rr_ring_arbiter
  import arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  output logic [N-1:0]            gnt,
  output logic [id_width(N)-1:0]  gnt_id,
  output logic                    busy,
  output logic                    timeout,
  output logic                    o_dbg_state,
  output logic [N-1:0]            o_dbg_ptr
);

  localparam int IDW = id_width(N);
  localparam int CW  = cnt_width(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  arb_state_e       r_state;
  logic [N-1:0]     r_ptr;
  logic [N-1:0]     r_gnt;
  logic [IDW-1:0]   r_gnt_id;
  logic [CW-1:0]    r_hold_cnt;
  logic             r_busy;
  logic             r_timeout;

  logic [N-1:0]     w_pick;
  logic             w_valid;
  logic [IDW-1:0]   w_pick_id;
  logic             w_owner_req;
  logic             w_release;
  logic [N-1:0]     w_ptr_rot;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .pick  (w_pick),
    .valid (w_valid)
  );

  // Encode the one-hot pick into an index, and decide whether the owner lets go.
  always_comb begin
    w_pick_id = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick[i]) begin
        w_pick_id = IDW'(i);
      end
    end
    w_owner_req = |(req & r_gnt);
    w_release   = !w_owner_req || (r_hold_cnt == HOLD_LAST);
    w_ptr_rot   = N'(rotl1(N_MAX'(r_gnt), N));
  end

  // Arbiter FSM, pointer, hold counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ptr      <= N'(1);
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_hold_cnt <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          if (w_valid) begin
            r_gnt      <= w_pick;
            r_gnt_id   <= w_pick_id;
            r_hold_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            // Owner becomes lowest priority; timeout only when it still wanted more.
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
            r_ptr      <= w_ptr_rot;
            r_timeout  <= w_owner_req;
            r_state    <= IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + CW'(1);
            r_timeout  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign gnt_id      = r_gnt_id;
  assign busy        = r_busy;
  assign timeout     = r_timeout;
  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule
